traffic_light_renderer: RTL

- Pixel-colour stage directly downstream of the VGA timing generator. Consumes its pixel coordinates, video_on, hsync and vsync.
- Draws two three-lamp traffic-light heads (NS and EW) on a black background from the controller's current light states. Emits 12-bit RGB plus re-aligned sync to the VGA connector.
- Runs on the 100 MHz system clock. Advances one pixel per detected coordinate change.

---
 rtl/traffic_light_renderer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_renderer.sv
// Pixel-colour stage for the traffic-light display.
// Turns timing-generator coordinates into 12-bit RGB showing the NS and EW
// lamp heads. Sync is re-aligned to the two-stage colour pipeline.
module traffic_light_renderer #(
   parameter int HEAD_NS_X    = 200,
   parameter int HEAD_EW_X    = 400,
   parameter int HEAD_Y       = 120,
   parameter int LAMP_SIZE    = 40,
   parameter int LAMP_GAP     = 10,
   parameter int HOUSING_PAD  = 8,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [1:0]  ns_light,
   input  logic [1:0]  ew_light,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync
);

   localparam int LAMP_STEP = LAMP_SIZE + LAMP_GAP;
   localparam int HEAD_H    = 3 * LAMP_SIZE + 2 * LAMP_GAP;
   localparam logic [10:0] NS_HX    = 11'(HEAD_NS_X);
   localparam logic [10:0] EW_HX    = 11'(HEAD_EW_X);
   localparam logic [10:0] HOUSE_Y0 = 11'(HEAD_Y - HOUSING_PAD);
   localparam logic [10:0] HOUSE_Y1 = 11'(HEAD_Y + HEAD_H + HOUSING_PAD);
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

   // bit i set when (px,py) is inside lamp i (0 red, 1 yellow, 2 green)
   function automatic logic [2:0] lamp_hits(input logic [10:0] px, input logic [10:0] py,
                                            input logic [10:0] hx);
      logic [2:0] hits;
      logic       x_in;
      x_in = in_span(px, hx, hx + 11'(LAMP_SIZE));
      for (int i = 0; i < 3; i++) begin
         hits[i] = x_in && in_span(py, 11'(HEAD_Y + i * LAMP_STEP),
                                   11'(HEAD_Y + i * LAMP_STEP + LAMP_SIZE));
      end
      return hits;
   endfunction

   function automatic logic housing_hit(input logic [10:0] px, input logic [10:0] py,
                                        input logic [10:0] hx);
      return in_span(px, hx - 11'(HOUSING_PAD), hx + 11'(LAMP_SIZE + HOUSING_PAD)) &&
             in_span(py, HOUSE_Y0, HOUSE_Y1);
   endfunction

   // one-hot of the lamp that should be lit; flashing yellow follows blink phase
   function automatic logic [2:0] lit_sel(input logic [1:0] st, input logic blink);
      case (st)
         2'b00:   return 3'b001;
         2'b01:   return 3'b010;
         2'b10:   return 3'b100;
         default: return {1'b0, blink, 1'b0};
      endcase
   endfunction

   logic [9:0]      x_q;
   logic            vsync_q;
   logic            pix_tick;
   logic            vsync_fall;
   logic [10:0]     xe;
   logic [10:0]     ye;

   logic            von_s1;
   logic            ns_house_s1;
   logic            ew_house_s1;
   logic [2:0]      ns_lamp_s1;
   logic [2:0]      ew_lamp_s1;
   logic            hs_s1;
   logic            vs_s1;

   logic [1:0]      ns_shadow;
   logic [1:0]      ew_shadow;
   logic [FC_W-1:0] frame_cnt;
   logic            blink_phase;

   logic [2:0]      lamp_any;
   logic [2:0]      lamp_lit;
   logic [11:0]     rgb_d;

   assign xe         = {1'b0, x};
   assign ye         = {1'b0, y};
   assign pix_tick   = (x != x_q);
   assign vsync_fall = vsync_q & ~vsync_in;

   // free-running copies used for pixel-change and frame-start detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q     <= '0;
         vsync_q <= 1'b1;
      end else begin
         x_q     <= x;
         vsync_q <= vsync_in;
      end
   end

   // stage 1: region hits for the current pixel, plus first sync delay
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         von_s1      <= 1'b0;
         ns_house_s1 <= 1'b0;
         ew_house_s1 <= 1'b0;
         ns_lamp_s1  <= '0;
         ew_lamp_s1  <= '0;
         hs_s1       <= 1'b1;
         vs_s1       <= 1'b1;
      end else if (pix_tick) begin
         von_s1      <= video_on;
         ns_house_s1 <= housing_hit(xe, ye, NS_HX);
         ew_house_s1 <= housing_hit(xe, ye, EW_HX);
         ns_lamp_s1  <= lamp_hits(xe, ye, NS_HX);
         ew_lamp_s1  <= lamp_hits(xe, ye, EW_HX);
         hs_s1       <= hsync_in;
         vs_s1       <= vsync_in;
      end
   end

   // colour selection: blanking, then lamps, then housing, then background
   always_comb begin
      lamp_any = ns_lamp_s1 | ew_lamp_s1;
      lamp_lit = (ns_lamp_s1 & lit_sel(ns_shadow, blink_phase)) |
                 (ew_lamp_s1 & lit_sel(ew_shadow, blink_phase));
      rgb_d    = 12'h000;
      if (!von_s1) begin
         rgb_d = 12'h000;
      end else if (lamp_any[0]) begin
         rgb_d = lamp_lit[0] ? 12'hF00 : 12'h400;
      end else if (lamp_any[1]) begin
         rgb_d = lamp_lit[1] ? 12'hFA0 : 12'h420;
      end else if (lamp_any[2]) begin
         rgb_d = lamp_lit[2] ? 12'h0F0 : 12'h040;
      end else if (ns_house_s1 || ew_house_s1) begin
         rgb_d = 12'h444;
      end
   end

   // stage 2: registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb   <= 12'h000;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else if (pix_tick) begin
         rgb   <= rgb_d;
         hsync <= hs_s1;
         vsync <= vs_s1;
      end
   end

   // light states latched at frame start so a frame never mixes two states
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ns_shadow   <= 2'b00;
         ew_shadow   <= 2'b00;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (vsync_fall) begin
         ns_shadow <= ns_light;
         ew_shadow <= ew_light;
         if (frame_cnt == FC_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

endmodule
